// File: rtl/ppt_regfile_pkg.sv
// ppt_regfile_pkg: register map offsets, reset defaults and constants for the PPT register file
package ppt_regfile_pkg;
  localparam logic [3:0] OFF_CLK_DIV    = 4'h0;
  localparam logic [3:0] OFF_PERIOD_L   = 4'h1;
  localparam logic [3:0] OFF_PERIOD_H   = 4'h2;
  localparam logic [3:0] OFF_WIDTH_L    = 4'h3;
  localparam logic [3:0] OFF_WIDTH_H    = 4'h4;
  localparam logic [3:0] OFF_COUNT_L    = 4'h5;
  localparam logic [3:0] OFF_COUNT_H    = 4'h6;
  localparam logic [3:0] OFF_CTRL       = 4'h7;
  localparam logic [3:0] OFF_CD_L       = 4'h8;
  localparam logic [3:0] OFF_CD_H       = 4'h9;
  localparam logic [3:0] OFF_STATUS     = 4'hA;
  localparam logic [3:0] OFF_IRQ_STATUS = 4'h0;
  localparam logic [3:0] OFF_IRQ_EN     = 4'h1;
  localparam logic [3:0] OFF_ID         = 4'h2;
  localparam logic [3:0] GLOBAL_PAGE    = 4'hF;
  localparam logic [7:0] ID_VALUE       = 8'hA2;
  localparam int RST_CLK_DIV = 9;
  localparam int RST_PERIOD  = 128;
  localparam int RST_WIDTH   = 1;
  localparam int RST_COUNT   = 16;
  localparam logic RST_RUN   = 1'b1;
endpackage

// File: rtl/ppt_regfile_if.sv
// ppt_regfile_if: byte-wide register bus between the I2C slave and the register file
interface ppt_regfile_if;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic write_enable;
  logic read_enable;
  modport master (output address, data_in, write_enable, read_enable, input data_out);
  modport slave (input address, data_in, write_enable, read_enable, output data_out);
endinterface

// File: rtl/ppt_reg_channel.sv
// ppt_reg_channel: one channel's shadow/active config, done-count snapshot, sticky done flag and read mux
module ppt_reg_channel
  import ppt_regfile_pkg::*;
#(
  parameter int CLKDIV_W = 5,
  parameter int PERIOD_W = 14,
  parameter int WIDTH_W  = 14,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sel,
  input  logic                write_enable,
  input  logic                read_enable,
  input  logic [3:0]          offset,
  input  logic [7:0]          data_in,
  input  logic [COUNT_W-1:0]  count_done,
  input  logic                done,
  output logic [CLKDIV_W-1:0] clk_div,
  output logic [PERIOD_W-1:0] period,
  output logic [WIDTH_W-1:0]  width,
  output logic [COUNT_W-1:0]  count,
  output logic                run,
  output logic                sticky,
  output logic [7:0]          rdata
);
  logic [CLKDIV_W-1:0] sh_div;
  logic [PERIOD_W-1:0] sh_per;
  logic [WIDTH_W-1:0]  sh_wid;
  logic [COUNT_W-1:0]  sh_cnt;
  logic [COUNT_W-1:0]  cd_q;
  logic [COUNT_W-9:0]  snap;
  logic done_q, done_d, wr, rd, rise, w1c;
  assign wr   = sel & write_enable;
  assign rd   = sel & read_enable;
  assign rise = done_q & ~done_d;
  assign w1c  = wr && offset == OFF_STATUS && data_in[1];
  // Shadow writes, atomic commit of shadow into active, and direct RUN update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_div  <= CLKDIV_W'(RST_CLK_DIV);
      sh_per  <= PERIOD_W'(RST_PERIOD);
      sh_wid  <= WIDTH_W'(RST_WIDTH);
      sh_cnt  <= COUNT_W'(RST_COUNT);
      clk_div <= CLKDIV_W'(RST_CLK_DIV);
      period  <= PERIOD_W'(RST_PERIOD);
      width   <= WIDTH_W'(RST_WIDTH);
      count   <= COUNT_W'(RST_COUNT);
      run     <= RST_RUN;
    end else if (wr) begin
      case (offset)
        OFF_CLK_DIV:  sh_div <= data_in[CLKDIV_W-1:0];
        OFF_PERIOD_L: sh_per[7:0] <= data_in;
        OFF_PERIOD_H: sh_per[PERIOD_W-1:8] <= data_in[PERIOD_W-9:0];
        OFF_WIDTH_L:  sh_wid[7:0] <= data_in;
        OFF_WIDTH_H:  sh_wid[WIDTH_W-1:8] <= data_in[WIDTH_W-9:0];
        OFF_COUNT_L:  sh_cnt[7:0] <= data_in;
        OFF_COUNT_H:  sh_cnt[COUNT_W-1:8] <= data_in[COUNT_W-9:0];
        OFF_CTRL: begin
          run <= data_in[0];
          if (data_in[1]) begin
            clk_div <= sh_div;
            period  <= sh_per;
            width   <= sh_wid;
            count   <= sh_cnt;
          end
        end
        default: ;
      endcase
    end
  end
  // Register controller inputs, latch the high-byte snapshot, and keep the sticky done flag (set beats clear)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cd_q   <= '0;
      done_q <= 1'b0;
      done_d <= 1'b0;
      snap   <= '0;
      sticky <= 1'b0;
    end else begin
      cd_q   <= count_done;
      done_q <= done;
      done_d <= done_q;
      if (rd && offset == OFF_CD_L) snap <= cd_q[COUNT_W-1:8];
      sticky <= rise | (sticky & ~w1c);
    end
  end
  // Read mux; returns zero when this channel's page is not addressed
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        OFF_CLK_DIV:  rdata = 8'(sh_div);
        OFF_PERIOD_L: rdata = sh_per[7:0];
        OFF_PERIOD_H: rdata = 8'(sh_per[PERIOD_W-1:8]);
        OFF_WIDTH_L:  rdata = sh_wid[7:0];
        OFF_WIDTH_H:  rdata = 8'(sh_wid[WIDTH_W-1:8]);
        OFF_COUNT_L:  rdata = sh_cnt[7:0];
        OFF_COUNT_H:  rdata = 8'(sh_cnt[COUNT_W-1:8]);
        OFF_CTRL:     rdata = {7'b0, run};
        OFF_CD_L:     rdata = cd_q[7:0];
        OFF_CD_H:     rdata = 8'(snap);
        OFF_STATUS:   rdata = {6'b0, sticky, done_q};
        default:      rdata = '0;
      endcase
    end
  end
endmodule

// File: rtl/ppt_regfile.sv
// ppt_regfile: page decode, global IRQ registers and read mux over NUM_CH PPT channel register blocks
module ppt_regfile
  import ppt_regfile_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CLKDIV_W = 5,
  parameter int PERIOD_W = 14,
  parameter int WIDTH_W  = 14,
  parameter int COUNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  ppt_regfile_if.slave               bus,
  output logic [NUM_CH*CLKDIV_W-1:0] clk_div,
  output logic [NUM_CH*PERIOD_W-1:0] period,
  output logic [NUM_CH*WIDTH_W-1:0]  width,
  output logic [NUM_CH*COUNT_W-1:0]  count,
  output logic [NUM_CH-1:0]          run_ppt,
  input  logic [NUM_CH*COUNT_W-1:0]  count_done,
  input  logic [NUM_CH-1:0]          done,
  output logic                       irq
);
  logic [3:0] page, offset;
  logic [NUM_CH-1:0] sticky, irq_en;
  logic [7:0] ch_rd [NUM_CH];
  logic [7:0] ch_or, glob;
  assign page   = bus.address[7:4];
  assign offset = bus.address[3:0];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ppt_reg_channel #(
      .CLKDIV_W(CLKDIV_W),
      .PERIOD_W(PERIOD_W),
      .WIDTH_W (WIDTH_W),
      .COUNT_W (COUNT_W)
    ) u_ch (
      .clk         (clk),
      .rstn        (rstn),
      .sel         (page == 4'(c)),
      .write_enable(bus.write_enable),
      .read_enable (bus.read_enable),
      .offset      (offset),
      .data_in     (bus.data_in),
      .count_done  (count_done[c*COUNT_W +: COUNT_W]),
      .done        (done[c]),
      .clk_div     (clk_div[c*CLKDIV_W +: CLKDIV_W]),
      .period      (period[c*PERIOD_W +: PERIOD_W]),
      .width       (width[c*WIDTH_W +: WIDTH_W]),
      .count       (count[c*COUNT_W +: COUNT_W]),
      .run         (run_ppt[c]),
      .sticky      (sticky[c]),
      .rdata       (ch_rd[c])
    );
  end
  // Per-channel interrupt enables in the global page
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_en <= '0;
    else if (bus.write_enable && page == GLOBAL_PAGE && offset == OFF_IRQ_EN) irq_en <= bus.data_in[NUM_CH-1:0];
  end
  // Channels gate their own read data by page select, so a plain OR merges them
  always_comb begin
    ch_or = '0;
    for (int i = 0; i < NUM_CH; i++) ch_or = ch_or | ch_rd[i];
  end
  assign glob = offset == OFF_IRQ_STATUS ? 8'(sticky) :
                offset == OFF_IRQ_EN     ? 8'(irq_en) :
                offset == OFF_ID         ? ID_VALUE : 8'h00;
  assign bus.data_out = page == GLOBAL_PAGE ? glob : ch_or;
  assign irq = |(sticky & irq_en);
endmodule

// File: doc/ppt_regfile.md
# ppt_regfile

Multi-channel, parametrised register file between the I2C slave interface and NUM_CH PPT pulse controllers. Each channel's configuration uses double-buffered shadow/active registers with an atomic commit. Multi-byte done counters read through a coherent snapshot. DONE events set sticky, write-1-to-clear flags that are aggregated into a single interrupt.

## Interface
- NUM_CH, 2, channel count (1..8)
- CLKDIV_W, 5, clock-divider field width (1..8)
- PERIOD_W, 14, period width (9..16)
- WIDTH_W, 14, pulse-width width (9..16)
- COUNT_W, 16, firing-count and done-count width (9..16)
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- address  in  8  {page[3:0], offset[3:0]}; page c = channel c, page 0xF = global
- data_in  in  8  write data
- write_enable  in  1  write strobe, one cycle per byte
- read_enable  in  1  read strobe, one cycle per byte, same cycle as address
- data_out  out  8  combinational read data for address
- clk_div  out  NUM_CH*CLKDIV_W  active dividers, channel c at [c*CLKDIV_W +: CLKDIV_W]
- period  out  NUM_CH*PERIOD_W  active periods, packed the same way
- width  out  NUM_CH*WIDTH_W  active pulse widths
- count  out  NUM_CH*COUNT_W  active firing counts
- run_ppt  out  NUM_CH  per-channel run enable
- count_done  in  NUM_CH*COUNT_W  firings completed, from the controllers
- done  in  NUM_CH  level done flag, from the controllers
- irq  out  1  level interrupt, active high

## Operation
- Channel offsets:
  - 0 CLK_DIV
  - 1/2 PERIOD_L/H
  - 3/4 WIDTH_L/H
  - 5/6 COUNT_L/H
  - 7 CTRL: bit0 RUN, bit1 COMMIT (write-only, reads 0)
  - 8/9 COUNT_DONE_L/H (read-only)
  - A STATUS: bit0 DONE live (RO), bit1 DONE_STICKY (W1C)
- Other offsets read 0; writes to them are ignored.
- H bytes hold bits [W-1:8]. Unimplemented bits read 0 and are ignored on write.
- Offsets 0–6 write the channel's shadow registers, and reads of 0–6 return shadow values.
- A CTRL write with bit1=1 copies all of that channel's shadow registers to active on the same edge.
- RUN is not shadowed. A CTRL write updates RUN directly in both cases.
- COMMIT and a RUN change in one write take effect on the same edge.
- count_done and done are registered every cycle, which adds 1 cycle of latency.
- COUNT_DONE_L reads the registered low byte.
- A read_enable at offset 8 latches the registered [COUNT_W-1:8] into a per-channel snapshot. Offset 9 returns that snapshot, so an L-then-H read sequence is coherent.
- DONE_STICKY sets on the rising edge of registered done.
- A W1C write clears DONE_STICKY. If a set and a clear land on the same edge, set wins.
- Global page 0xF:
  - F0 IRQ_STATUS: bit c = DONE_STICKY of channel c (RO)
  - F1 IRQ_EN: bit c enables channel c (RW)
  - F2 ID: constant 8'hA2 (RO)
- irq = |(IRQ_STATUS & IRQ_EN[NUM_CH-1:0]).
- Pages ≥ NUM_CH other than 0xF read 0; writes to them are ignored.

## Timing
- Register writes take effect on the clk edge where write_enable=1.
- A COMMIT is visible on the outputs the cycle after that edge.
- data_out is combinational on address.
- Snapshot latch: the read_enable edge at offset 8 latches; an offset-9 read is valid from the next cycle.
- Reset values, applied to both shadow and active registers and identical for every channel:
  - CLK_DIV 9
  - PERIOD 128
  - WIDTH 1
  - COUNT 16
  - RUN 1 (fallback operation without I2C)
- Also cleared at reset: IRQ_EN, DONE_STICKY, the done/count_done registers, the snapshots and irq.
- Reset asserted mid-operation discards all pending shadow writes immediately.
- done high during reset: the first post-reset cycle samples done, with the previous value 0, so the sticky flag sets.
- write_enable and read_enable may be high in the same cycle. Write data is not visible to that cycle's data_out.
- A write to a read-only offset does not change state.

## Structure
- Package ppt_regfile_pkg holds:
  - offset constants
  - reset defaults
  - ID value
  - GLOBAL_PAGE = 4'hF
- Sub-module ppt_reg_channel, instantiated NUM_CH times in a generate loop, holds:
  - shadow/active registers
  - snapshot
  - done edge detect and sticky flag
  - per-channel read mux
- Top level holds the page decode, the global registers, the output mux and the irq OR.

## Test plan
- Reset with NUM_CH=2, then read every channel offset.
  - Response: 0x09, 0x80, 0x00, 0x01, 0x00, 0x10, 0x00, 0x01, 0, 0, 0; F2 reads 0xA2; outputs at defaults; run_ppt=2'b11.
- Write 0x34 to 0x11 and 0x12 to 0x12.
  - Response: period for channel 1 stays 128 and the shadow reads back 0x34/0x12.
  - Then write 0x03 to 0x17: period for channel 1 is 0x1234 the next cycle and channel 0 is unchanged.
- Hold count_done[ch0]=0x01FF, read 0x08 → 0xFF.
  - Change count_done to 0x0200, then read 0x09 → 0x01 (snapshot).
  - Re-read 0x08 → 0x00, then 0x09 → 0x02.
- Pulse done[1] 0→1 with IRQ_EN=0x02.
  - Response: STATUS 0x1A reads 0x03; F0 = 0x02; irq=1.
  - Write 0x02 to 0x1A while done stays high: irq=0 and STATUS reads 0x01.
- Issue a W1C on the exact edge of a new done rise.
  - Response: sticky remains 1 and irq remains 1.
- Write 0xFF to 0x02.
  - Response: reads back 0x3F.
  - Write to page 0x5 with NUM_CH=2: no state changes and reads return 0.
- Assert rstn mid-sequence after shadow writes.
  - Response: all outputs return to defaults asynchronously.
